// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner encoding, default widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  localparam int MASK_W_DEF = DATA_W_DEF / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Grant vector bit order: [0] = IFU, [1] = LSU.
  function automatic logic [1:0] own2grant(input owner_e o);
    return (o == OWN_LSU) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Requester pick: fixed LSU priority, or round-robin tie-break when MEM_ARB_RR_EN is defined.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  owner_e     last_owner,
  output logic [1:0] grant,
  output owner_e     winner
);

  always_comb begin
    winner = OWN_LSU;
`ifdef MEM_ARB_RR_EN
    if (ifu_valid && lsu_valid)
      winner = (last_owner == OWN_LSU) ? OWN_IFU : OWN_LSU;
    else if (ifu_valid)
      winner = OWN_IFU;
`else
    if (ifu_valid && !lsu_valid)
      winner = OWN_IFU;
`endif
    grant = '0;
    if (ifu_valid || lsu_valid)
      grant = own2grant(winner);
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between IFU (read) and LSU (read/write); one transaction in flight.
// Optional round-robin tie-break via MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef struct packed {
    logic              wen;
    owner_e            owner;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } req_t;

  state_e     state, state_nxt;
  req_t       req_q, req_new;
  owner_e     last_owner, winner;
  logic [1:0] grant;
  logic       accept, rsp_hit;

  mem_arb_pick u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_owner (last_owner),
    .grant      (grant),
    .winner     (winner)
  );

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst)         last_owner <= OWN_IFU;
    else if (accept) last_owner <= winner;
  end
`else
  assign last_owner = OWN_IFU;
`endif

  // Ready is withheld while rst is high so nothing is accepted in a reset cycle.
  assign ifu_req_ready = (state == ST_IDLE) && !rst && grant[0];
  assign lsu_req_ready = (state == ST_IDLE) && !rst && grant[1];
  assign accept        = (ifu_req_ready && ifu_req_valid) || (lsu_req_ready && lsu_req_valid);
  assign rsp_hit       = (state == ST_WAIT) && mem_rsp_valid && !rst;

  always_comb begin
    req_new       = '0;
    req_new.owner = winner;
    if (winner == OWN_LSU) begin
      req_new.wen   = lsu_wen;
      req_new.addr  = lsu_addr;
      req_new.wdata = lsu_wdata;
      req_new.wmask = lsu_wen ? lsu_wmask : '0;
    end else begin
      req_new.addr  = ifu_addr;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)        state_nxt = ST_REQ;
      ST_REQ:  if (mem_req_ready) state_nxt = ST_WAIT;
      ST_WAIT: if (mem_rsp_valid) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) req_q <= req_new;
    end
  end

  assign mem_req_valid = (state == ST_REQ);
  assign mem_wen       = req_q.wen;
  assign mem_addr      = req_q.addr;
  assign mem_wdata     = req_q.wdata;
  assign mem_wmask     = req_q.wmask;

  assign ifu_rsp_valid = rsp_hit && (req_q.owner == OWN_IFU);
  assign lsu_rsp_valid = rsp_hit && (req_q.owner == OWN_LSU);
  assign ifu_rdata     = ifu_rsp_valid ? mem_rdata : '0;
  assign lsu_rdata     = lsu_rsp_valid ? mem_rdata : '0;

  assign busy = (state != ST_IDLE);

endmodule
